uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for 8N1 serial frames: 8 data bits, no parity, 1 stop bit, LSB first. It sits between the RX pin and the fabric, as the receive-side counterpart of the UART transmitter. It synchronizes the asynchronous line and samples each bit at its centre. Each received byte is presented with a single-cycle valid strobe; frames with a bad stop bit are flagged as framing errors.

## Interface
- CLK_FREQ, 12_000_000: system clock frequency in Hz.
- BAUD, 115200: baud rate.
- Derived constant CLKS_PER_BIT = CLK_FREQ / BAUD (integer divide; 104 at defaults).
- Derived constant HALF_BIT = CLKS_PER_BIT / 2 (52 at defaults).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low. Single clock domain.
- rx_in  input  1  serial line from the pin; asynchronous; idles high.
- rx_data  output  8  last good received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data has just been updated.
- rx_frame_err  output  1  one-cycle pulse when the stop bit sampled low.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Input synchronizer: 2-flop synchronizer on rx_in, both flops reset to 1. All FSM decisions use the second flop, rx_sync.
- Counters:
  - clk_count: 16 bits, wide enough for CLKS_PER_BIT - 1.
  - bit_index: 3 bits.
  - shift register: 8 bits.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_IDLE.
- IDLE: clk_count = 0, bit_index = 0. When rx_sync == 0, go to START_BIT.
- START_BIT: count to HALF_BIT - 1, then sample rx_sync.
  - Sample 0: clear clk_count and go to DATA_BITS.
  - Sample 1: glitch or false start. Return to IDLE with no output pulse.
- DATA_BITS: count to CLKS_PER_BIT - 1, then sample.
  - Shift right, inserting rx_sync at bit 7, so the byte is LSB first.
  - Increment bit_index. After the 8th sample, clear bit_index and go to STOP_BIT.
- STOP_BIT: count to CLKS_PER_BIT - 1, then sample.
  - Sample 1: rx_data <= shift register, pulse rx_valid, go to IDLE.
  - Sample 0: pulse rx_frame_err, leave rx_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_sync == 1, then go to IDLE. This prevents a break condition (line held low) from retriggering endlessly.
- rx_valid and rx_frame_err are never high in the same cycle.
- Illegal state encodings recover to IDLE on the next clock.

## Timing
- Reset values:
  - rx_data = 8'h00; rx_valid, rx_frame_err, rx_busy = 0.
  - Both synchronizer flops = 1; FSM = IDLE.
  - Reset takes effect immediately and asynchronously, including mid-frame. After release, the block waits for a fresh falling edge.
- Synchronizer latency: 2 clk from an rx_in transition to rx_sync.
- rx_busy rises 1 clk after rx_sync first reads 0 in IDLE.
- Sampling points, measured from the start edge as seen on rx_sync: HALF_BIT into the start bit, then every CLKS_PER_BIT.
- Valid latency: rx_valid asserts 9*CLKS_PER_BIT + HALF_BIT + 3 clk (±1) after the rx_in falling edge. At defaults that is 991 ±1 clk.
- rx_valid and rx_frame_err are exactly 1 clk wide. rx_data is stable from the rx_valid cycle onward.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start bit that immediately follows the stop bit is caught with no lost frame.
- A low pulse shorter than HALF_BIT clk produces no output. rx_busy drops after at most HALF_BIT + 1 clk.
- Baud mismatch up to ±3% between transmitter and receiver must decode correctly.
- No downstream backpressure: a new byte overwrites rx_data. The consumer must take each byte on rx_valid.

## Test plan
- Clean frame: drive byte 0x55 at 115200 baud, default clock -> exactly one rx_valid pulse, rx_data = 0x55, rx_frame_err never high, rx_busy returns to 0.
- Back-to-back frames: send 0x00, then 0xFF, then 0xA5 with zero idle gap -> three rx_valid pulses in order with rx_data 0x00, 0xFF, 0xA5. Spacing between pulses is 10*CLKS_PER_BIT ±1 clk.
- Glitch rejection: hold rx_in low for 20 clk, then high -> no rx_valid, no rx_frame_err, rx_busy deasserted within 53 clk, rx_data unchanged.
- Framing error and break: send 0xA5 with the stop bit driven low, then hold the line low for 3 bit times before releasing -> one rx_frame_err pulse, no rx_valid, rx_data keeps its previous value. The next clean 0x3C is received correctly.
- Reset mid-frame: assert rst_n low during data bit 4 of 0x96 -> all outputs 0 immediately and no pulse. After release, a clean 0x96 is received correctly.
- Baud tolerance: send 0x3C with the bit period at 101 and then 107 clk -> rx_data = 0x3C in both cases with no frame error.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : uart_rx                                                 |
// | Purpose  : 8N1 UART receiver. Synchronizes the RX line, samples    |
// |            each bit at its centre, strobes good bytes and flags    |
// |            frames whose stop bit reads low.                        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int          c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          c_HALF_BIT     = c_CLKS_PER_BIT / 2;
  localparam logic [15:0] c_BIT_LAST     = 16'(c_CLKS_PER_BIT - 1);
  localparam logic [15:0] c_HALF_LAST    = 16'(c_HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_BIT = 3'd1,
    S_DATA_BITS = 3'd2,
    S_STOP_BIT  = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic        r_sync_meta;
  logic        r_sync;
  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_clk_count;
  logic [2:0]  r_bit_index;
  logic [7:0]  r_shift;
  logic        w_half_done;
  logic        w_bit_done;

  assign w_half_done = (r_clk_count == c_HALF_LAST);
  assign w_bit_done  = (r_clk_count == c_BIT_LAST);
  assign rx_busy     = (r_state != S_IDLE);

  // Two-flop synchronizer; idle-high reset so no false start comes out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
    end else begin
      r_sync_meta <= rx_in;
      r_sync      <= r_sync_meta;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; unknown encodings fall back to IDLE
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:      w_next_state = r_sync ? S_IDLE : S_START_BIT;
      S_START_BIT: begin
        w_next_state = S_START_BIT;
        if (w_half_done) w_next_state = r_sync ? S_IDLE : S_DATA_BITS;
      end
      S_DATA_BITS: begin
        w_next_state = S_DATA_BITS;
        if (w_bit_done && (r_bit_index == 3'd7)) w_next_state = S_STOP_BIT;
      end
      S_STOP_BIT: begin
        w_next_state = S_STOP_BIT;
        // Leaving at mid-stop-bit lets a directly following start edge be caught
        if (w_bit_done) w_next_state = r_sync ? S_IDLE : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: w_next_state = r_sync ? S_IDLE : S_WAIT_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Bit timing, data shifting and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_count  <= 16'd0;
      r_bit_index  <= 3'd0;
      r_shift      <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (r_state)
        S_START_BIT: begin
          if (w_half_done) r_clk_count <= 16'd0;
          else             r_clk_count <= r_clk_count + 16'd1;
        end
        S_DATA_BITS: begin
          if (w_bit_done) begin
            r_clk_count <= 16'd0;
            r_shift     <= {r_sync, r_shift[7:1]};
            // Wraps to zero after the eighth bit
            r_bit_index <= r_bit_index + 3'd1;
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end
        S_STOP_BIT: begin
          if (w_bit_done) begin
            r_clk_count <= 16'd0;
            if (r_sync) begin
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            r_clk_count <= r_clk_count + 16'd1;
          end
        end
        default: begin
          r_clk_count <= 16'd0;
          r_bit_index <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_uart_rx                                              |
// | Purpose  : Self-checking bench for uart_rx with directed and       |
// |            randomized frames against a byte-stream model.          |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_uart_rx;

  localparam int c_BIT = 104;
  localparam int c_HALF = 52;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(12_000_000), .BAUD(115200)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed event log
  logic [7:0] obs_q[$];
  int         obs_t[$];
  int         err_cnt = 0;
  int         wide_cnt = 0;
  int         both_cnt = 0;
  int         drift_cnt = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back(rx_data);
      obs_t.push_back(cyc);
    end
    if (rx_frame_err) err_cnt++;
    if ((rx_valid && prev_valid) || (rx_frame_err && prev_err)) wide_cnt++;
    if (rx_valid && rx_frame_err) both_cnt++;
    if (rst_n && !rx_valid && (rx_data !== prev_data)) drift_cnt++;
    prev_valid = rx_valid;
    prev_err   = rx_frame_err;
    prev_data  = rx_data;
  end

  // Reference model: the ordered stream of bytes that must appear, and the held byte
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         ptr = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int t_fall   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int period);
    rx_in = v;
    repeat (period) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input logic stop);
    t_fall = cyc;
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(b[i], period);
    drive_bit(stop, period);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    last_good = b;
  endtask

  // Compare everything received since the previous call against the model
  task automatic check_stream(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = ptr; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, last_good});
    ptr = obs_q.size();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t_rise;
    int k;
    int d;
    logic [7:0] b;
    int per;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_err", {31'd0, rx_frame_err}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", {31'd0, rx_busy}, 32'd0);

    // Clean frame 0x55 with latency measurement
    send_frame(8'h55, c_BIT, 1'b1);
    repeat (50) @(negedge clk);
    expect_byte(8'h55);
    check_stream("clean55");
    check("clean55_err", err_cnt, 0);
    check("clean55_busy", {31'd0, rx_busy}, 32'd0);
    if (obs_t.size() > 0) begin
      d = obs_t[0] - t_fall;
      check("clean55_latency_990_992", {31'd0, (d >= 990 && d <= 992)}, 32'd1);
    end

    // Back-to-back frames with no idle gap
    e0 = obs_t.size();
    send_frame(8'h00, c_BIT, 1'b1);
    send_frame(8'hFF, c_BIT, 1'b1);
    send_frame(8'hA5, c_BIT, 1'b1);
    repeat (50) @(negedge clk);
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'hA5);
    check_stream("b2b");
    if (obs_t.size() == e0 + 3) begin
      for (int i = 1; i < 3; i++) begin
        d = obs_t[e0 + i] - obs_t[e0 + i - 1];
        check("b2b_spacing", {31'd0, (d >= 10 * c_BIT - 1 && d <= 10 * c_BIT + 1)}, 32'd1);
      end
    end

    // Glitch of 20 clk: busy must be short-lived and nothing reported
    t_rise = -1;
    rx_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy && t_rise < 0) t_rise = cyc;
    end
    rx_in = 1'b1;
    k = 0;
    while (rx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("glitch_busy_seen", {31'd0, (t_rise >= 0)}, 32'd1);
    check("glitch_busy_drop", {31'd0, rx_busy}, 32'd0);
    check("glitch_busy_len_le_53", {31'd0, (t_rise >= 0 && cyc - t_rise <= c_HALF + 1)}, 32'd1);
    repeat (20) @(negedge clk);
    check_stream("glitch");
    check("glitch_err", err_cnt, 0);

    // Framing error followed by a 3-bit break, then a clean frame
    send_frame(8'hA5, c_BIT, 1'b0);
    repeat (3 * c_BIT) @(negedge clk);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_count", err_cnt, 1);
    check_stream("ferr");
    check("ferr_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, c_BIT, 1'b1);
    repeat (50) @(negedge clk);
    expect_byte(8'h3C);
    check_stream("after_ferr");

    // Reset asserted in the middle of data bit 4 of 0x96
    b = 8'h96;
    drive_bit(1'b0, c_BIT);
    for (int i = 0; i < 4; i++) drive_bit(b[i], c_BIT);
    drive_bit(b[4], 50);
    rst_n = 1'b0;
    #1;
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_err", {31'd0, rx_frame_err}, 32'd0);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    last_good = 8'h00;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    check_stream("midrst_quiet");
    send_frame(8'h96, c_BIT, 1'b1);
    repeat (50) @(negedge clk);
    expect_byte(8'h96);
    check_stream("midrst_recover");

    // Baud tolerance at both ends
    send_frame(8'h3C, 101, 1'b1);
    repeat (50) @(negedge clk);
    expect_byte(8'h3C);
    check_stream("baud101");
    send_frame(8'h3C, 107, 1'b1);
    repeat (50) @(negedge clk);
    expect_byte(8'h3C);
    check_stream("baud107");
    check("baud_err", err_cnt, 1);

    // Randomized bytes, bit periods and idle gaps
    for (int n = 0; n < 10; n++) begin
      b   = 8'($urandom_range(0, 255));
      per = int'($urandom_range(101, 107));
      send_frame(b, per, 1'b1);
      expect_byte(b);
      rx_in = 1'b1;
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    check_stream("random");

    // Global properties gathered over the whole run
    check("final_err_count", err_cnt, 1);
    check("pulse_width_1clk", wide_cnt, 0);
    check("valid_err_exclusive", both_cnt, 0);
    check("rx_data_hold", drift_cnt, 0);
    check("final_busy", {31'd0, rx_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
